whack_game_ctrl: RTL and testbench

Round sequencer for the whack-a-mole arcade game. Drives the timer block's `reset_timer` input and consumes its elapsed-time outputs and edge flags. Each round it picks a random LED and a random delay, lights the LED, and measures reaction time. It also keeps last and best times over `N_ROUNDS` rounds.

---
 rtl/whack_game_pkg.sv | 44 ++++
 rtl/whack_timer_if.sv | 27 ++
 rtl/whack_lfsr.sv | 27 ++
 rtl/whack_game_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_whack_game_ctrl.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/whack_game_pkg.sv
// whack_game_pkg
//   Shared types and constants for the whack-a-mole round sequencer.
//   - state_t     : FSM states (FOUL exists only when FOUL_DETECT_EN is defined)
//   - sample_t    : decoded LFSR sample (LED select + long delay flag)
//   - MISS_TIME   : result recorded for a missed or fouled round
//   - LFSR_TAPS   : feedback taps for x^8+x^6+x^5+x^4+1
//   - TIME_W      : width of all time values (hundredths, 0..999)
// Optional feature macro: FOUL_DETECT_EN
package whack_game_pkg;

  localparam int TIME_W = 10;
  localparam logic [TIME_W-1:0] MISS_TIME = 10'd999;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_DELAY,
    MOLE_ON,
    RESULT,
    DONE
`ifdef FOUL_DETECT_EN
    , FOUL
`endif
  } state_t;

  typedef struct packed {
    logic       long_delay;
    logic [2:0] sel_led;
  } sample_t;

  // N_LEDS is a power of two, so the modulo reduces to a mask.
  function automatic sample_t decode_sample(input logic [7:0] lfsr, input int n_leds);
    sample_t s;
    s.long_delay = lfsr[7];
    s.sel_led    = lfsr[2:0] & 3'(n_leds - 1);
    return s;
  endfunction

  function automatic logic [TIME_W-1:0] min_time(input logic [TIME_W-1:0] a,
                                                 input logic [TIME_W-1:0] b);
    return (b < a) ? b : a;
  endfunction

endpackage

// File: rtl/whack_timer_if.sv
// whack_timer_if
//   Link between the round sequencer and the reaction timer block.
//   - reset_timer          : restart request to the timer (active-high)
//   - display_timer        : elapsed hundredths since last restart, 0..999
//   - timer_*_edge         : one-cycle threshold flags (0.2 s, 1 s, 3 s, 9.99 s)
//   master = game controller, slave = timer block.
interface whack_timer_if;
  import whack_game_pkg::*;

  logic              reset_timer;
  logic [TIME_W-1:0] display_timer;
  logic              timer_0point2_edge;
  logic              timer_1_edge;
  logic              timer_3_edge;
  logic              timer_9point99_edge;

  modport master (
    output reset_timer,
    input  display_timer, timer_0point2_edge, timer_1_edge, timer_3_edge, timer_9point99_edge
  );

  modport slave (
    input  reset_timer,
    output display_timer, timer_0point2_edge, timer_1_edge, timer_3_edge, timer_9point99_edge
  );

endinterface

// File: rtl/whack_lfsr.sv
// whack_lfsr
//   Free-running 8-bit Fibonacci LFSR, shifts left every clock.
//   Ports: clk, reset_n (async, active-low), lfsr (current state).
//   SEED must be nonzero or the register locks up at zero.
module whack_lfsr
  import whack_game_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic [7:0] lfsr
);

  logic [7:0] r_lfsr;
  logic       w_fb;

  assign w_fb = ^(r_lfsr & LFSR_TAPS);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_lfsr <= SEED;
    else          r_lfsr <= {r_lfsr[6:0], w_fb};
  end

  assign lfsr = r_lfsr;

endmodule

// File: rtl/whack_game_ctrl.sv
// whack_game_ctrl
//   Round sequencer for the whack-a-mole game. Picks a random LED and delay
//   per round, lights the mole, measures reaction time via the timer block,
//   and tracks last/best times over N_ROUNDS rounds.
//   Ports: clk, reset_n (async, active-low), start_btn, whack (1-cycle pulses),
//          tmr (timer link, master side), led_onehot, last_time, best_time,
//          round_cnt, hit, miss, game_done. All outputs registered.
//   Optional feature macro: FOUL_DETECT_EN (whack during the delay is a foul).
//
//   state      | meaning
//   IDLE       | waiting for start_btn, timer held in reset
//   WAIT_DELAY | random 1 s / 3 s pre-mole delay
//   MOLE_ON    | LED lit, waiting for whack or 9.99 s timeout
//   RESULT     | LEDs off, round tallied, 1 s pause
//   FOUL       | early whack, all LEDs on for 0.2 s (FOUL_DETECT_EN only)
//   DONE       | game over, results held, timer held in reset
module whack_game_ctrl
  import whack_game_pkg::*;
#(
  parameter int         N_ROUNDS  = 5,
  parameter int         N_LEDS    = 8,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start_btn,
  input  logic              whack,
  whack_timer_if.master     tmr,
  output logic [N_LEDS-1:0] led_onehot,
  output logic [TIME_W-1:0] last_time,
  output logic [TIME_W-1:0] best_time,
  output logic [3:0]        round_cnt,
  output logic              hit,
  output logic              miss,
  output logic              game_done
);

  localparam logic [N_LEDS-1:0] LED_ONE = N_LEDS'(1);

  state_t            r_state;
  sample_t           r_sample;
  logic              r_reset_timer;
  logic              r_blank;
  logic [N_LEDS-1:0] r_led;
  logic [TIME_W-1:0] r_last;
  logic [TIME_W-1:0] r_best;
  logic [3:0]        r_round;
  logic              r_hit;
  logic              r_miss;
  logic              r_done;

  logic [7:0]        w_lfsr;
  sample_t           w_sample;
  logic              w_edge_ok;
  logic              w_e1;
  logic              w_e3;
  logic              w_e999;
  logic              w_delay_edge;

  whack_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk    (clk),
    .reset_n(reset_n),
    .lfsr   (w_lfsr)
  );

  assign w_sample = decode_sample(w_lfsr, N_LEDS);

  // Edges are blanked while the timer restarts and for one cycle after, so a
  // threshold flag left over from the previous interval cannot fire early.
  assign w_edge_ok    = !r_reset_timer && !r_blank;
  assign w_e1         = tmr.timer_1_edge        && w_edge_ok;
  assign w_e3         = tmr.timer_3_edge        && w_edge_ok;
  assign w_e999       = tmr.timer_9point99_edge && w_edge_ok;
  assign w_delay_edge = r_sample.long_delay ? w_e3 : w_e1;

`ifdef FOUL_DETECT_EN
  logic w_e02;
  assign w_e02 = tmr.timer_0point2_edge && w_edge_ok;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_sample      <= '0;
      r_reset_timer <= 1'b1;
      r_blank       <= 1'b0;
      r_led         <= '0;
      r_last        <= '0;
      r_best        <= MISS_TIME;
      r_round       <= '0;
      r_hit         <= 1'b0;
      r_miss        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_reset_timer <= 1'b0;
      r_blank       <= r_reset_timer;
      r_hit         <= 1'b0;
      r_miss        <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          r_reset_timer <= 1'b1;
          if (start_btn) begin
            r_state  <= WAIT_DELAY;
            r_sample <= w_sample;
            r_round  <= '0;
            r_best   <= MISS_TIME;
            r_last   <= '0;
            r_done   <= 1'b0;
          end
        end
        WAIT_DELAY: begin
`ifdef FOUL_DETECT_EN
          if (whack) begin
            r_state       <= FOUL;
            r_reset_timer <= 1'b1;
            r_led         <= '1;
          end else
`endif
          if (w_delay_edge) begin
            r_state       <= MOLE_ON;
            r_reset_timer <= 1'b1;
            r_led         <= LED_ONE << r_sample.sel_led;
          end
        end
        MOLE_ON: begin
          // A whack landing on the timeout edge still counts as a hit.
          if (whack) begin
            r_state       <= RESULT;
            r_reset_timer <= 1'b1;
            r_led         <= '0;
            r_last        <= tmr.display_timer;
            r_hit         <= 1'b1;
          end else if (w_e999) begin
            r_state       <= RESULT;
            r_reset_timer <= 1'b1;
            r_led         <= '0;
            r_last        <= MISS_TIME;
            r_miss        <= 1'b1;
          end
        end
        RESULT: begin
          // r_reset_timer is high only in the first RESULT cycle.
          if (r_reset_timer) begin
            r_round <= r_round + 4'd1;
            r_best  <= min_time(r_best, r_last);
          end else if (w_e1) begin
            r_reset_timer <= 1'b1;
            if (r_round == 4'(N_ROUNDS)) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state  <= WAIT_DELAY;
              r_sample <= w_sample;
            end
          end
        end
`ifdef FOUL_DETECT_EN
        FOUL: begin
          if (w_e02) begin
            r_state       <= RESULT;
            r_reset_timer <= 1'b1;
            r_led         <= '0;
            r_last        <= MISS_TIME;
            r_miss        <= 1'b1;
          end
        end
`endif
        default: r_state <= IDLE;
      endcase
    end
  end

  assign tmr.reset_timer = r_reset_timer;
  assign led_onehot      = r_led;
  assign last_time       = r_last;
  assign best_time       = r_best;
  assign round_cnt       = r_round;
  assign hit             = r_hit;
  assign miss            = r_miss;
  assign game_done       = r_done;

endmodule

// File: tb/tb_whack_game_ctrl.sv
// tb_whack_game_ctrl
//   Self-checking bench for whack_game_ctrl: a reference LFSR predicts the
//   LED/delay picks, a scoreboard queue holds expected round results, and a
//   vector table drives a full five-round game.
module tb_whack_game_ctrl;
  import whack_game_pkg::*;

  localparam int         N_ROUNDS = 5;
  localparam int         N_LEDS   = 8;
  localparam logic [7:0] SEED     = 8'hA5;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start_btn = 1'b0;
  logic              whack = 1'b0;
  logic [N_LEDS-1:0] led_onehot;
  logic [9:0]        last_time;
  logic [9:0]        best_time;
  logic [3:0]        round_cnt;
  logic              hit;
  logic              miss;
  logic              game_done;

  whack_timer_if tmr();

  always #5 clk = ~clk;

  whack_game_ctrl #(.N_ROUNDS(N_ROUNDS), .N_LEDS(N_LEDS), .LFSR_SEED(SEED)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start_btn (start_btn),
    .whack     (whack),
    .tmr       (tmr),
    .led_onehot(led_onehot),
    .last_time (last_time),
    .best_time (best_time),
    .round_cnt (round_cnt),
    .hit       (hit),
    .miss      (miss),
    .game_done (game_done)
  );

  // Reference LFSR from x^8+x^6+x^5+x^4+1, shifting left.
  logic [7:0] m_lfsr;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) m_lfsr <= SEED;
    else          m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  typedef struct {
    logic [9:0] last;
    logic       hit;
    logic       miss;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    int         t;
    bit         do_whack;
    bit         do_edge;
    logic [9:0] e_last;
    bit         e_hit;
    bit         e_miss;
    logic [9:0] e_best;
    logic [3:0] e_round;
  } vec_t;

  int       n_checks = 0;
  int       n_fail   = 0;
  logic [2:0] e_sel;
  bit         e_long;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic capture_sample();
    e_sel  = m_lfsr[2:0] & 3'(N_LEDS - 1);
    e_long = m_lfsr[7];
  endtask

  task automatic start_game(input bit want_short);
    int guard = 0;
    @(negedge clk);
    while (want_short && m_lfsr[7] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (want_short && m_lfsr[7]) begin
      n_checks++;
      n_fail++;
      $display("FAIL short_delay_wait: no short-delay sample within 50 cycles");
    end
    capture_sample();
    start_btn = 1'b1;
    @(negedge clk);
    start_btn = 1'b0;
    chk("start_reset_timer", tmr.reset_timer, 1);
    chk("start_round_cnt", round_cnt, 0);
    chk("start_best", best_time, 999);
    chk("start_last", last_time, 0);
    chk("start_game_done", game_done, 0);
    chk("start_led", led_onehot, 0);
  endtask

  // Enters from the first WAIT_DELAY cycle, returns in the first MOLE_ON cycle.
  task automatic to_mole(input bit stale, input bit wwhack);
    if (stale) begin
      tmr.timer_1_edge = 1'b1;
      tmr.timer_3_edge = 1'b1;
    end
    @(negedge clk);
    chk("wait_reset_timer_low", tmr.reset_timer, 0);
    if (wwhack) whack = 1'b1;
    @(negedge clk);
    tmr.timer_1_edge = 1'b0;
    tmr.timer_3_edge = 1'b0;
    whack = 1'b0;
    chk("wait_led_off", led_onehot, 0);
    chk("wait_reset_timer_low2", tmr.reset_timer, 0);
    if (e_long) tmr.timer_3_edge = 1'b1;
    else        tmr.timer_1_edge = 1'b1;
    @(negedge clk);
    tmr.timer_1_edge = 1'b0;
    tmr.timer_3_edge = 1'b0;
    chk("mole_led", led_onehot, 32'(1) << e_sel);
    chk("mole_reset_timer", tmr.reset_timer, 1);
  endtask

  task automatic check_result();
    sb_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_empty: no expected result queued");
    end else begin
      e = sb_q.pop_front();
      chk("result_last", last_time, e.last);
      chk("result_hit", hit, e.hit);
      chk("result_miss", miss, e.miss);
      chk("result_led", led_onehot, 0);
    end
  endtask

  task automatic tally_and_exit(input logic [9:0] e_best, input logic [3:0] e_round);
    @(negedge clk);
    chk("tally_round_cnt", round_cnt, e_round);
    chk("tally_best", best_time, e_best);
    chk("pulse_cleared", {hit, miss}, 0);
    @(negedge clk);
    capture_sample();
    tmr.timer_1_edge = 1'b1;
    @(negedge clk);
    tmr.timer_1_edge = 1'b0;
    chk("exit_reset_timer", tmr.reset_timer, 1);
  endtask

  // Enters in the first MOLE_ON cycle.
  task automatic finish_round(input vec_t v);
    @(negedge clk);
    @(negedge clk);
    tmr.display_timer       = 10'(v.t);
    whack                   = v.do_whack;
    tmr.timer_9point99_edge = v.do_edge;
    sb_q.push_back('{v.e_last, v.e_hit, v.e_miss});
    @(negedge clk);
    whack                   = 1'b0;
    tmr.timer_9point99_edge = 1'b0;
    check_result();
    tally_and_exit(v.e_best, v.e_round);
  endtask

  vec_t tbl[5];

  initial begin
    tbl[0] = '{50,  1, 0, 10'd50,  1, 0, 10'd50, 4'd1};
    tbl[1] = '{20,  1, 0, 10'd20,  1, 0, 10'd20, 4'd2};
    tbl[2] = '{400, 0, 1, 10'd999, 0, 1, 10'd20, 4'd3};
    tbl[3] = '{20,  1, 0, 10'd20,  1, 0, 10'd20, 4'd4};
    tbl[4] = '{80,  1, 0, 10'd80,  1, 0, 10'd20, 4'd5};

    tmr.display_timer       = '0;
    tmr.timer_0point2_edge  = 1'b0;
    tmr.timer_1_edge        = 1'b0;
    tmr.timer_3_edge        = 1'b0;
    tmr.timer_9point99_edge = 1'b0;

    repeat (3) @(negedge clk);
    chk("reset_reset_timer", tmr.reset_timer, 1);
    chk("reset_led", led_onehot, 0);
    chk("reset_best", best_time, 999);
    chk("reset_game_done", game_done, 0);
    reset_n = 1'b1;

    // Game 1: hit, timeout miss, simultaneous hit+timeout with stale edges,
    // whack during the delay, then reset mid-round.
    start_game(1'b1);
    to_mole(1'b0, 1'b0);
    finish_round('{37,  1, 0, 10'd37,  1, 0, 10'd37, 4'd1});
    to_mole(1'b0, 1'b0);
    finish_round('{500, 0, 1, 10'd999, 0, 1, 10'd37, 4'd2});
    to_mole(1'b1, 1'b0);
    finish_round('{999, 1, 1, 10'd999, 1, 0, 10'd37, 4'd3});
`ifdef FOUL_DETECT_EN
    @(negedge clk);
    whack = 1'b1;
    @(negedge clk);
    whack = 1'b0;
    chk("foul_led_all", led_onehot, {N_LEDS{1'b1}});
    chk("foul_reset_timer", tmr.reset_timer, 1);
    @(negedge clk);
    @(negedge clk);
    tmr.timer_0point2_edge = 1'b1;
    sb_q.push_back('{10'd999, 1'b0, 1'b1});
    @(negedge clk);
    tmr.timer_0point2_edge = 1'b0;
    check_result();
    tally_and_exit(10'd37, 4'd4);
`else
    to_mole(1'b0, 1'b1);
    finish_round('{60, 1, 0, 10'd60, 1, 0, 10'd37, 4'd4});
`endif
    to_mole(1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("midreset_reset_timer", tmr.reset_timer, 1);
    chk("midreset_led", led_onehot, 0);
    chk("midreset_last", last_time, 0);
    chk("midreset_best", best_time, 999);
    chk("midreset_round_cnt", round_cnt, 0);
    chk("midreset_pulses", {hit, miss, game_done}, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Game 2: table-driven five-round game.
    start_game(1'b0);
    for (int i = 0; i < 5; i++) begin
      to_mole(1'b0, 1'b0);
      finish_round(tbl[i]);
    end
    chk("done_game_done", game_done, 1);
    chk("done_round_cnt", round_cnt, 5);
    chk("done_best", best_time, 20);
    repeat (3) @(negedge clk);
    chk("done_reset_timer_held", tmr.reset_timer, 1);
    chk("done_hold_last", last_time, 80);
    chk("done_hold_flag", game_done, 1);
    chk("done_led", led_onehot, 0);
    start_game(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
